// File: rtl/icache_set_assoc.sv
// Set-associative read-only instruction cache: zero-latency hits, true-LRU replacement,
// a single outstanding line fill, and a global invalidate.
module icache_set_assoc #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  req_valid_miss,
    output logic [ADDR_WIDTH-1:0] req_addr_miss,
    input  logic                  rsp_valid_miss,
    input  logic [LINE_WIDTH-1:0] rsp_data_miss,
    input  logic                  invalidate_all
);

    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;
    localparam int WW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WW-1:0] AGE_MAX = WW'(NUM_WAYS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t state_r, state_next_s;

    logic [LINE_WIDTH-1:0] data_r [NUM_SETS][NUM_WAYS];
    logic [TAG-1:0]        tag_r  [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]         valid_r;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][WW-1:0] age_r;

    logic                  pending_r;
    logic [WW-1:0]         victim_r;
    logic                  req_valid_miss_r;
    logic [ADDR_WIDTH-1:0] req_addr_miss_r;

    logic [ADDR_WIDTH-1:0] line_addr_s;
    logic [TAG-1:0]        req_tag_s, miss_tag_s;
    logic [IDX-1:0]        req_idx_s, miss_idx_s;
    logic [NUM_WAYS-1:0]   hit_vec_s;
    logic                  hit_s;
    logic [WW-1:0]         hit_way_s, victim_s;
    logic [LINE_WIDTH-1:0] hit_data_s;

    logic                  miss_start_s, fill_we_s, touch_en_s;
    logic [IDX-1:0]        touch_set_s;
    logic [WW-1:0]         touch_way_s, touch_age_s;
    logic                  rsp_valid_s;
    logic [LINE_WIDTH-1:0] rsp_data_s;

    assign line_addr_s = req_addr & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    assign req_tag_s   = req_addr[ADDR_WIDTH-1:IDX+OFF];
    assign req_idx_s   = req_addr[IDX+OFF-1:OFF];
    // The in-flight miss is addressed only through the latched line address.
    assign miss_tag_s  = req_addr_miss_r[ADDR_WIDTH-1:IDX+OFF];
    assign miss_idx_s  = req_addr_miss_r[IDX+OFF-1:OFF];
    assign touch_age_s = age_r[touch_set_s][touch_way_s];

    // Tag compare across all ways of the requested set; tags within a set are unique.
    always_comb begin
        hit_vec_s  = '0;
        hit_way_s  = '0;
        hit_data_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s);
            hit_way_s    = hit_way_s | (WW'(w) & {WW{hit_vec_s[w]}});
            hit_data_s   = hit_data_s | (data_r[req_idx_s][w] & {LINE_WIDTH{hit_vec_s[w]}});
        end
        hit_s = |hit_vec_s;
    end

    // Victim: lowest-numbered invalid way, else the oldest way.
    always_comb begin
        victim_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            victim_s = (age_r[req_idx_s][w] == AGE_MAX) ? WW'(w) : victim_s;
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            victim_s = !valid_r[req_idx_s][w] ? WW'(w) : victim_s;
        end
    end

    // Miss FSM next-state and response/update strobes.
    always_comb begin
        state_next_s = state_r;
        miss_start_s = 1'b0;
        fill_we_s    = 1'b0;
        touch_en_s   = 1'b0;
        touch_set_s  = req_idx_s;
        touch_way_s  = hit_way_s;
        rsp_valid_s  = 1'b0;
        rsp_data_s   = '0;
        case (state_r)
            IDLE: begin
                if (req_valid && hit_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = hit_data_s;
                    touch_en_s  = 1'b1;
                end else if (req_valid) begin
                    miss_start_s = 1'b1;
                    state_next_s = MISS_REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MISS_REQ: begin
                state_next_s = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (rsp_valid_miss) begin
                    fill_we_s    = 1'b1;
                    rsp_valid_s  = 1'b1;
                    rsp_data_s   = rsp_data_miss;
                    touch_en_s   = 1'b1;
                    touch_set_s  = miss_idx_s;
                    touch_way_s  = victim_r;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MISS_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Miss bookkeeping and the registered fill-request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_valid_miss_r <= 1'b0;
            req_addr_miss_r  <= '0;
            victim_r         <= '0;
        end else begin
            req_valid_miss_r <= (state_next_s == MISS_REQ);
            if (miss_start_s) begin
                req_addr_miss_r <= line_addr_s;
                victim_r        <= victim_s;
            end
        end
    end

    // A flush seen while a fill is outstanding must keep that fill from becoming valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                      pending_r <= 1'b0;
        else if (state_next_s == IDLE)                  pending_r <= 1'b0;
        else if (invalidate_all && (state_r != IDLE))   pending_r <= 1'b1;
    end

    // Valid bits: flush has priority over the fill write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)               valid_r <= '0;
        else if (invalidate_all) valid_r <= '0;
        else if (fill_we_s)      valid_r[miss_idx_s][victim_r] <= ~pending_r;
    end

    // LRU ages: touched way becomes 0, younger ways age by one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age_r[s][w] <= WW'(w);
        end else if (touch_en_s) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WW'(w) == touch_way_s)
                    age_r[touch_set_s][w] <= '0;
                else if (age_r[touch_set_s][w] < touch_age_s)
                    age_r[touch_set_s][w] <= age_r[touch_set_s][w] + WW'(1'b1);
            end
        end
    end

    // Data and tag storage carry no reset; validity is tracked separately.
    always_ff @(posedge clock) begin
        if (fill_we_s) begin
            data_r[miss_idx_s][victim_r] <= rsp_data_miss;
            tag_r[miss_idx_s][victim_r]  <= miss_tag_s;
        end
    end

    assign req_ready      = (state_r == IDLE);
    assign rsp_valid      = rsp_valid_s;
    assign rsp_data       = rsp_data_s;
    assign req_valid_miss = req_valid_miss_r;
    assign req_addr_miss  = req_addr_miss_r;

endmodule
